// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: sequences operand loads over the
// shared bus, steers the subtractor, and reports done/err with an iteration limit.
module gcd_controller #(
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              lda,
  output logic              ldb,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_SUB_A,
    S_SUB_B,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef struct packed {
    logic lda;
    logic ldb;
    logic sel1;
    logic sel2;
    logic sel_in;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] iter_nxt;
  ctrl_t             ctrl_nxt;

  // Outputs are registered copies of the decode of the next state, so they
  // remain a pure function of the state register while being glitch-free.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD_A: begin
        c.sel_in = 1'b1;
        c.lda    = 1'b1;
        c.busy   = 1'b1;
      end
      S_LOAD_B: begin
        c.sel_in = 1'b1;
        c.ldb    = 1'b1;
        c.busy   = 1'b1;
      end
      S_CMP: c.busy = 1'b1;
      S_SUB_A: begin
        c.sel1 = 1'b0;
        c.sel2 = 1'b1;
        c.lda  = 1'b1;
        c.busy = 1'b1;
      end
      S_SUB_B: begin
        c.sel1 = 1'b1;
        c.sel2 = 1'b0;
        c.ldb  = 1'b1;
        c.busy = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      S_ERR:   c.err  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_count;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_LOAD_A;
          iter_nxt  = '0;
        end
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_CMP;
      S_CMP: begin
        // Limit check sits between eq and gt/lt so a finished result still wins
        // at the limit, and the counter can never step past MAX_ITER.
        if (eq)                         state_nxt = S_DONE;
        else if (iter_count == ITER_LIMIT) state_nxt = S_ERR;
        else if (gt)                    state_nxt = S_SUB_A;
        else if (lt)                    state_nxt = S_SUB_B;
        else                            state_nxt = S_ERR;
      end
      S_SUB_A, S_SUB_B: begin
        state_nxt = S_CMP;
        iter_nxt  = iter_count + ITER_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ctrl_nxt = decode(state_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      iter_count <= '0;
      lda        <= 1'b0;
      ldb        <= 1'b0;
      sel1       <= 1'b0;
      sel2       <= 1'b0;
      sel_in     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      iter_count <= iter_nxt;
      lda        <= ctrl_nxt.lda;
      ldb        <= ctrl_nxt.ldb;
      sel1       <= ctrl_nxt.sel1;
      sel2       <= ctrl_nxt.sel2;
      sel_in     <= ctrl_nxt.sel_in;
      busy       <= ctrl_nxt.busy;
      done       <= ctrl_nxt.done;
      err        <= ctrl_nxt.err;
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller: a behavioural datapath closes the loop,
// a reference GCD model predicts outcome, count and latency of each run.
module tb_gcd_controller;

  localparam int unsigned ITER_W   = 4;
  localparam int unsigned MAX_ITER = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic gt, lt, eq;
  logic lda, ldb, sel1, sel2, sel_in, busy, done, err;
  logic [ITER_W-1:0] iter_count;

  gcd_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [7:0] ra = '0, rb = '0, cur_a = '0, cur_b = '0;
  logic [7:0] data_in, sub_out;
  logic       force_en = 1'b0;
  logic [2:0] force_val = '0;  // {gt, lt, eq}
  assign data_in = ldb ? cur_b : cur_a;
  assign sub_out = (sel1 ? rb : ra) - (sel2 ? rb : ra);
  assign gt = force_en ? force_val[2] : (ra > rb);
  assign lt = force_en ? force_val[1] : (ra < rb);
  assign eq = force_en ? force_val[0] : (ra == rb);
  always @(posedge clk) begin
    if (lda) ra <= sel_in ? data_in : sub_out;
    if (ldb) rb <= sel_in ? data_in : sub_out;
  end

  int cyc = 0;
  logic start_q = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    start_q <= start;
  end

  typedef struct {
    bit         is_err;
    int         k;
    logic [7:0] res;
    bit         chk_res;
    int         e0;
  } exp_t;
  exp_t q[$];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: Euclid by repeated subtraction with a cap on the number of steps.
  function automatic exp_t ref_run(input logic [7:0] a_in, input logic [7:0] b_in);
    exp_t e;
    int unsigned a = a_in, b = b_in;
    e = '{default: 0};
    e.chk_res = 1'b1;
    forever begin
      if (a == b) begin
        e.res = a[7:0];
        return e;
      end
      if (e.k == int'(MAX_ITER)) begin
        e.is_err = 1'b1;
        return e;
      end
      if (a > b) a = a - b;
      else       b = b - a;
      e.k++;
    end
  endfunction

  // Monitor
  logic prev_done = 1'b0, prev_err = 1'b0, mon_off = 1'b0;
  always @(negedge clk) begin
    if (!mon_off) begin
      if (prev_done) chk("done_hold", done, !start_q);
      if (prev_err)  chk("err_hold", err, !start_q);
      if ((done && !prev_done) || (err && !prev_err)) begin
        if (q.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("end_done", done, !e.is_err);
          chk("end_err", err, e.is_err);
          chk("iter_count", iter_count, e.k);
          chk("latency", cyc - e.e0, e.is_err ? 3 + 2 * e.k : 3 + 2 * e.k);
          if (!e.is_err && e.chk_res) chk("result", ra, e.res);
        end
      end
      chk("busy", busy, q.size() != 0);
      chk("iter_bound", iter_count <= ITER_W'(MAX_ITER), 1);
      prev_done <= done;
      prev_err  <= err;
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input bit fen, input logic [2:0] fv);
    exp_t e;
    int n;
    if (!fen) e = ref_run(a, b);
    else begin
      e = '{default: 0};
      e.is_err  = !fv[0] && !fv[1] && !fv[2];
      e.res     = a;
      e.chk_res = fv[0];
      if (fv[0]) e.is_err = 1'b0;
    end
    cur_a = a; cur_b = b; force_en = fen; force_val = fv;
    start = 1'b1;
    @(posedge clk); #1;
    e.e0 = cyc;
    q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (done || err) break;
      start = 1'($urandom_range(0, 1));  // ignored while busy
      n++;
      if (n > 100) begin
        chk("run_timeout", n, 0);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {lda, ldb, sel1, sel2, sel_in, busy, done, err}, 0);
    chk({tag, "_iter"}, iter_count, 0);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    issue(8'd12, 8'd8, 0, 3'b000);
    issue(8'd5,  8'd5, 0, 3'b000);
    issue(8'd0,  8'd7, 0, 3'b000);
    issue(8'd9,  8'd6, 0, 3'b000);
    issue(8'd0,  8'd0, 0, 3'b000);
    issue(8'd7,  8'd0, 0, 3'b000);
    issue(8'd12, 8'd8, 1, 3'b000);
    issue(8'd12, 8'd8, 1, 3'b101);
    repeat (2) @(negedge clk);

    // Abort in SUB_A with an asynchronous reset
    cur_a = 8'd12; cur_b = 8'd8; force_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    q.push_back('{is_err: 1'b0, k: 2, res: 8'd4, chk_res: 1'b1, e0: cyc});
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(lda && !sel_in) && n < 20);
    chk("reach_sub_a", lda && !sel_in, 1);
    #2 rst = 1'b1;
    mon_off = 1'b1;
    q.delete();
    #1 check_reset_outputs("abort");
    @(negedge clk);
    #2 rst = 1'b0;
    prev_done = 1'b0; prev_err = 1'b0;
    @(negedge clk);
    mon_off = 1'b0;
    issue(8'd9, 8'd6, 0, 3'b000);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      issue(8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)), 0, 3'b000);
    end

    n = 0;
    while (q.size() != 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM for the subtractive GCD datapath. It sequences operand loading over the shared `data_in` bus and drives the register-load and mux selects: `lda`, `ldb`, `sel1`, `sel2`, `sel_in`. It consumes the comparator flags (`gt`, `lt`, `eq`) and returns a `start`/`done` handshake to the host. An iteration limit flags non-terminating inputs, such as a zero operand.

## Interface
- `ITER_W`, 16: width of the subtraction-iteration counter.
- `MAX_ITER`, 65535: maximum subtractions allowed before the error state is entered. Must be below 2^ITER_W.

- `clk`  in  1  rising-edge clock shared with the datapath.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new GCD computation. Sampled only in IDLE, DONE and ERR.
- `gt`, `lt`, `eq`  in  1 each  comparator flags for A vs B from the datapath.
- `lda`, `ldb`  out  1 each  load enables for registers A and B.
- `sel1`  out  1  subtractor minuend select: 0 = A, 1 = B.
- `sel2`  out  1  subtractor subtrahend select: 0 = A, 1 = B.
- `sel_in`  out  1  bus source: 1 = `data_in`, 0 = subtractor output.
- `busy`  out  1  a computation is in progress (LOAD_A through SUB_B).
- `done`  out  1  result valid in register A; held until the next accepted start or reset.
- `err`  out  1  iteration limit hit or illegal flag combination; held until the next accepted start or reset.
- `iter_count`  out  ITER_W  number of subtractions in the current or last run.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE, ERR.
- All outputs are Moore, decoded from the state register only. `iter_count` is a register.
- IDLE / DONE / ERR:
  - All load enables and selects are 0.
  - `start=1` moves to LOAD_A, clears `iter_count` to 0 and deasserts `done`/`err`.
  - `start=0` stays in the current state.
- LOAD_A: `sel_in=1`, `lda=1`. The host drives operand A on `data_in` during this cycle. Next state is LOAD_B.
- LOAD_B: `sel_in=1`, `ldb=1`. The host drives operand B during this cycle. Next state is CMP.
- CMP: no loads. Flags are evaluated with priority `eq` > `gt` > `lt`:
  - `eq` moves to DONE.
  - Otherwise, if `iter_count == MAX_ITER`, move to ERR.
  - Otherwise `gt` moves to SUB_A and `lt` moves to SUB_B.
  - No flag set moves to ERR.
- SUB_A: `sel1=0`, `sel2=1`, `sel_in=0`, `lda=1`, so A <= A - B. `iter_count` increments. Next state is CMP.
- SUB_B: `sel1=1`, `sel2=0`, `sel_in=0`, `ldb=1`, so B <= B - A. `iter_count` increments. Next state is CMP.
- `start` is ignored in LOAD_A through SUB_B. It is never queued.
- `iter_count` never exceeds MAX_ITER. The limit check precedes any increment, so no wrap is possible.
- A zero operand with a nonzero partner never reaches `eq`. It must terminate in ERR after exactly MAX_ITER subtractions.
- A=B=0 gives `eq` on the first CMP, so the block reaches DONE with result 0.

## Timing
- Reset (asynchronous, applies immediately):
  - State is IDLE.
  - `lda`, `ldb`, `sel1`, `sel2`, `sel_in`, `busy`, `done`, `err` are 0.
  - `iter_count` is 0.
- Reset mid-operation aborts to IDLE with no `done`. The datapath A/B registers are not reset, and their contents are undefined for the host.
- Edge numbering: edge 0 is the rising edge that samples `start=1`.
  - Operand A is captured at edge 1.
  - Operand B is captured at edge 2.
  - The first CMP occupies the cycle after edge 2.
- Each subtraction costs 2 cycles (SUB then CMP).
- For a run with k subtractions, `done` rises after edge 3+2k.
- ERR is reached after edge 3+2·MAX_ITER in the limit case, or after edge 3+2k in the illegal-flag case.
- `busy` is high from edge 0 until the edge that enters DONE or ERR.
- Back-to-back runs: `start` held high in DONE is accepted on the next edge, so `done` is high for exactly 1 cycle.

## Test plan
- A=12, B=8 (sequence SUB_A, SUB_B) -> `done` rises after edge 7, `iter_count`=2, register A=4, `err`=0.
- A=B=5 -> `done` after edge 3, `iter_count`=0, register A=5.
- MAX_ITER=4, A=0, B=7 -> four SUB_B cycles, then `err`=1 after edge 11, `iter_count`=4, `done`=0.
- A=12, B=8, with `start` pulsed again at edges 3 and 5 -> no effect. Completion is identical to the first case, and `start` at the DONE cycle restarts from LOAD_A.
- Assert `rst` mid-cycle while in SUB_A -> all outputs are 0 immediately, state is IDLE. A subsequent start with A=9, B=6 gives `done` after edge 7 with result 3.
- Force `gt`=`lt`=`eq`=0 during CMP -> ERR on the next edge. Force `eq`=`gt`=1 -> DONE (eq priority).
